// File: rtl/ysyx_22040759_axi_pkg.sv
// Shared definitions for the data-side AXI4 master: FSM encoding, AXI field constants
// and the access-size to byte-strobe / data-mask mappings.
package ysyx_22040759_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [7:0] size_to_strb(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] size_to_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 64'h0000_0000_0000_00FF;
            2'b01:   return 64'h0000_0000_0000_FFFF;
            2'b10:   return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_axi_align.sv
// Combinational lane steering: write strobe/data shifted up to the byte lane of addr[2:0],
// read data shifted down to bit 0 and masked to the access size.
module ysyx_22040759_axi_align
    import ysyx_22040759_axi_pkg::*;
(
    input  logic [2:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [7:0]  o_wstrb,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata
);

    logic [5:0] w_shamt;

    assign w_shamt = {i_addr_lo, 3'b000};
    // Strobe bits shifted past lane 7 fall off: accesses crossing 8 bytes are unsupported.
    assign o_wstrb = size_to_strb(i_size) << i_addr_lo;
    assign o_wdata = i_wdata << w_shamt;
    assign o_rdata = (i_rdata >> w_shamt) & size_to_mask(i_size);

endmodule

// File: rtl/ysyx_22040759_axi_master.sv
// Single-outstanding AXI4 master bridging the MEM-stage read/write request channels.
// Optional response checking is enabled with `define YSYX_22040759_AXI_RESP_CHECK_EN.
module ysyx_22040759_axi_master
    import ysyx_22040759_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'd1,
    parameter int         AXI_ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  mem_rd_addr_valid_i,
    input  logic [63:0]           mem_rd_addr_i,
    input  logic [1:0]            mem_rd_size_i,
    output logic                  mem_rd_data_valid_o,
    output logic [63:0]           mem_rd_data_o,

    input  logic                  mem_wr_addr_valid_i,
    input  logic [63:0]           mem_wr_addr_i,
    input  logic [63:0]           mem_wr_data_i,
    input  logic [1:0]            mem_wr_size_i,
    output logic                  mem_wr_data_valid_o,

    output logic                  mem_bus_err_o,

    output logic                  axi_arvalid_o,
    output logic [AXI_ADDR_W-1:0] axi_araddr_o,
    output logic [3:0]            axi_arid_o,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    input  logic                  axi_arready_i,

    input  logic                  axi_rvalid_i,
    input  logic [63:0]           axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic [3:0]            axi_rid_i,
    output logic                  axi_rready_o,

    output logic                  axi_awvalid_o,
    output logic [AXI_ADDR_W-1:0] axi_awaddr_o,
    output logic [3:0]            axi_awid_o,
    output logic [7:0]            axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    input  logic                  axi_awready_i,

    output logic                  axi_wvalid_o,
    output logic [63:0]           axi_wdata_o,
    output logic [7:0]            axi_wstrb_o,
    output logic                  axi_wlast_o,
    input  logic                  axi_wready_i,

    input  logic                  axi_bvalid_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic [3:0]            axi_bid_i,
    output logic                  axi_bready_o
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic                  r_rd_done, r_wr_done, r_bus_err;
    logic                  w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
    logic                  w_rd_done_nxt, w_wr_done_nxt;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [1:0]            r_size;
    logic [63:0]           r_wdata;
    logic [7:0]            r_wstrb;
    logic [63:0]           r_rd_data;
    logic                  w_aw_pend, w_w_pend, w_rd_hs, w_b_hs;
    logic [2:0]            w_al_addr;
    logic [1:0]            w_al_size;
    logic [7:0]            w_al_wstrb;
    logic [63:0]           w_al_wdata, w_al_rdata;

    assign w_aw_pend = r_awvalid & ~axi_awready_i;
    assign w_w_pend  = r_wvalid & ~axi_wready_i;
    assign w_rd_hs   = r_rready & axi_rvalid_i;
    assign w_b_hs    = r_bready & axi_bvalid_i;

    // In IDLE the aligner prepares the incoming write; afterwards it serves the latched request.
    assign w_al_addr = (r_state == S_IDLE) ? mem_wr_addr_i[2:0] : r_addr[2:0];
    assign w_al_size = (r_state == S_IDLE) ? mem_wr_size_i      : r_size;

    ysyx_22040759_axi_align u_align (
        .i_addr_lo (w_al_addr),
        .i_size    (w_al_size),
        .i_wdata   (mem_wr_data_i),
        .i_rdata   (axi_rdata_i),
        .o_wstrb   (w_al_wstrb),
        .o_wdata   (w_al_wdata),
        .o_rdata   (w_al_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_wr_addr_valid_i)      w_state_nxt = S_WR_REQ;
                else if (mem_rd_addr_valid_i) w_state_nxt = S_RD_ADDR;
            end
            S_RD_ADDR: if (r_arvalid && axi_arready_i) w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (w_rd_hs)                    w_state_nxt = S_DONE;
            S_WR_REQ:  if (!w_aw_pend && !w_w_pend)    w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (w_b_hs)                     w_state_nxt = S_DONE;
            default:                                   w_state_nxt = S_IDLE;
        endcase
    end

    // Next-cycle values for the registered handshake outputs.
    always_comb begin
        w_arvalid_nxt = (w_state_nxt == S_RD_ADDR);
        w_rready_nxt  = (w_state_nxt == S_RD_DATA);
        w_bready_nxt  = (w_state_nxt == S_WR_RESP);
        w_rd_done_nxt = (r_state == S_RD_DATA) && (w_state_nxt == S_DONE);
        w_wr_done_nxt = (r_state == S_WR_RESP) && (w_state_nxt == S_DONE);
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        if ((r_state == S_IDLE) && (w_state_nxt == S_WR_REQ)) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
        end else if (r_state == S_WR_REQ) begin
            w_awvalid_nxt = w_aw_pend;
            w_wvalid_nxt  = w_w_pend;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            r_rd_data <= 64'd0;
        end else begin
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_wr_done <= w_wr_done_nxt;
            if (w_rd_hs) r_rd_data <= w_al_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == S_IDLE) begin
            if (mem_wr_addr_valid_i) begin
                r_addr  <= mem_wr_addr_i[AXI_ADDR_W-1:0];
                r_size  <= mem_wr_size_i;
                r_wdata <= w_al_wdata;
                r_wstrb <= w_al_wstrb;
            end else if (mem_rd_addr_valid_i) begin
                r_addr  <= mem_rd_addr_i[AXI_ADDR_W-1:0];
                r_size  <= mem_rd_size_i;
            end
        end
    end

`ifdef YSYX_22040759_AXI_RESP_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if ((w_rd_hs && ((axi_rresp_i != AXI_RESP_OKAY) || (axi_rid_i != AXI_ID))) ||
                     (w_b_hs  && ((axi_bresp_i != AXI_RESP_OKAY) || (axi_bid_i != AXI_ID)))) begin
            r_bus_err <= 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = ^{mem_rd_addr_i, mem_wr_addr_i, axi_rlast_i};
`else
    assign r_bus_err = 1'b0;

    logic w_unused;
    assign w_unused = ^{mem_rd_addr_i, mem_wr_addr_i, axi_rlast_i,
                        axi_rresp_i, axi_rid_i, axi_bresp_i, axi_bid_i};
`endif

    assign mem_rd_data_valid_o = r_rd_done;
    assign mem_rd_data_o       = r_rd_data;
    assign mem_wr_data_valid_o = r_wr_done;
    assign mem_bus_err_o       = r_bus_err;

    assign axi_arvalid_o = r_arvalid;
    assign axi_araddr_o  = r_addr;
    assign axi_arid_o    = AXI_ID;
    assign axi_arlen_o   = 8'd0;
    assign axi_arsize_o  = {1'b0, r_size};
    assign axi_arburst_o = AXI_BURST_INCR;
    assign axi_rready_o  = r_rready;

    assign axi_awvalid_o = r_awvalid;
    assign axi_awaddr_o  = r_addr;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = 8'd0;
    assign axi_awsize_o  = {1'b0, r_size};
    assign axi_awburst_o = AXI_BURST_INCR;

    assign axi_wvalid_o  = r_wvalid;
    assign axi_wdata_o   = r_wdata;
    assign axi_wstrb_o   = r_wstrb;
    assign axi_wlast_o   = 1'b1;

    assign axi_bready_o  = r_bready;

endmodule
